// File: rtl/hbm_mvm_csr_pkg.sv
// Shared definitions for the transposed-MVM CSR slave: register map, response codes,
// FSM state types and the configuration bundle handed to the MVM_afterTRP core.
package hbm_mvm_csr_pkg;

   localparam int CFG_TOKEN_W = 16;
   localparam int CFG_HEAD_W  = 8;

   localparam logic [7:0] OFF_CTRL            = 8'h00;
   localparam logic [7:0] OFF_STATUS          = 8'h04;
   localparam logic [7:0] OFF_DAT_IN_BASE     = 8'h08;
   localparam logic [7:0] OFF_DAT_IN_HSTRIDE  = 8'h0C;
   localparam logic [7:0] OFF_DAT_IN_LSTRIDE  = 8'h10;
   localparam logic [7:0] OFF_WT_BASE         = 8'h14;
   localparam logic [7:0] OFF_DAT_OUT_BASE    = 8'h18;
   localparam logic [7:0] OFF_DAT_OUT_HSTRIDE = 8'h1C;
   localparam logic [7:0] OFF_DAT_OUT_LSTRIDE = 8'h20;
   localparam logic [7:0] OFF_TOKEN           = 8'h24;
   localparam logic [7:0] OFF_FEATURE_HEAD    = 8'h28;
   localparam logic [7:0] OFF_WEIGHT_HEAD     = 8'h2C;
   localparam logic [7:0] OFF_KV_CACHE_MODE   = 8'h30;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;

   typedef enum logic [3:0] {
      REG_CTRL, REG_STATUS, REG_DIN_BASE, REG_DIN_HSTR, REG_DIN_LSTR, REG_WT_BASE,
      REG_DOUT_BASE, REG_DOUT_HSTR, REG_DOUT_LSTR, REG_TOKEN, REG_FHEAD, REG_WHEAD,
      REG_KV, REG_NONE
   } reg_id_t;

   typedef struct packed {
      logic [31:0]            dat_in_base;
      logic [31:0]            dat_in_head_stride;
      logic [31:0]            dat_in_line_stride;
      logic [31:0]            wt_base;
      logic [31:0]            dat_out_base;
      logic [31:0]            dat_out_head_stride;
      logic [31:0]            dat_out_line_stride;
      logic [CFG_TOKEN_W-1:0] token;
      logic [CFG_HEAD_W-1:0]  feature_head;
      logic [CFG_HEAD_W-1:0]  weight_head;
      logic                   kv_cache_mode;
   } cfg_t;

   function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                              input logic [31:0] wr_val,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++)
         if (strb[i]) res[8*i +: 8] = wr_val[8*i +: 8];
      return res;
   endfunction

endpackage

// File: rtl/hbm_mvm_trp_csr_slave.sv
// AXI4-Lite register slave for the transposed-MVM core: holds the layout config,
// launches the core with a one-cycle start pulse and tracks busy / sticky done / irq.
//
// state  | meaning
// W_IDLE | collecting AW and W beats (either order), update when both are held
// W_RESP | write response presented, waiting for bready
// R_IDLE | arready high, waiting for a read address
// R_DATA | read data presented, waiting for rready
module hbm_mvm_trp_csr_slave
   import hbm_mvm_csr_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int TOKEN_W = CFG_TOKEN_W,
   parameter int HEAD_W  = CFG_HEAD_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_awvalid,
   output logic              s_awready,
   input  logic [ADDR_W-1:0] s_awaddr,
   input  logic              s_wvalid,
   output logic              s_wready,
   input  logic [DATA_W-1:0] s_wdata,
   input  logic [3:0]        s_wstrb,
   output logic              s_bvalid,
   input  logic              s_bready,
   output logic [1:0]        s_bresp,
   input  logic              s_arvalid,
   output logic              s_arready,
   input  logic [ADDR_W-1:0] s_araddr,
   output logic              s_rvalid,
   input  logic              s_rready,
   output logic [DATA_W-1:0] s_rdata,
   output logic [1:0]        s_rresp,
   output logic [31:0]       cfg_dat_in_base,
   output logic [31:0]       cfg_dat_in_head_stride,
   output logic [31:0]       cfg_dat_in_line_stride,
   output logic [31:0]       cfg_wt_base,
   output logic [31:0]       cfg_dat_out_base,
   output logic [31:0]       cfg_dat_out_head_stride,
   output logic [31:0]       cfg_dat_out_line_stride,
   output logic [TOKEN_W-1:0] cfg_token,
   output logic [HEAD_W-1:0] cfg_feature_head,
   output logic [HEAD_W-1:0] cfg_weight_head,
   output logic              cfg_kv_cache_mode,
   output logic              core_start,
   input  logic              core_done,
   output logic              irq
);

   function automatic reg_id_t reg_decode(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] word;
      word = addr >> 2;
      case (word)
         ADDR_W'(OFF_CTRL >> 2):            return REG_CTRL;
         ADDR_W'(OFF_STATUS >> 2):          return REG_STATUS;
         ADDR_W'(OFF_DAT_IN_BASE >> 2):     return REG_DIN_BASE;
         ADDR_W'(OFF_DAT_IN_HSTRIDE >> 2):  return REG_DIN_HSTR;
         ADDR_W'(OFF_DAT_IN_LSTRIDE >> 2):  return REG_DIN_LSTR;
         ADDR_W'(OFF_WT_BASE >> 2):         return REG_WT_BASE;
         ADDR_W'(OFF_DAT_OUT_BASE >> 2):    return REG_DOUT_BASE;
         ADDR_W'(OFF_DAT_OUT_HSTRIDE >> 2): return REG_DOUT_HSTR;
         ADDR_W'(OFF_DAT_OUT_LSTRIDE >> 2): return REG_DOUT_LSTR;
         ADDR_W'(OFF_TOKEN >> 2):           return REG_TOKEN;
         ADDR_W'(OFF_FEATURE_HEAD >> 2):    return REG_FHEAD;
         ADDR_W'(OFF_WEIGHT_HEAD >> 2):     return REG_WHEAD;
         ADDR_W'(OFF_KV_CACHE_MODE >> 2):   return REG_KV;
         default:                           return REG_NONE;
      endcase
   endfunction

   wstate_t           wstate;
   rstate_t           rstate;
   cfg_t              cfg;
   logic              busy, done, irq_en, start_q;
   logic              have_aw, have_w;
   logic [ADDR_W-1:0] aw_q;
   logic [DATA_W-1:0] w_q;
   logic [3:0]        strb_q;

   logic              aw_fire, w_fire, do_write, wr_cfg, wr_err, wr_ok, done_set;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [3:0]        wr_strb;
   reg_id_t           wr_reg, rd_reg;
   logic [31:0]       rd_val;
   logic              rd_err;

   // A beat arriving in the same cycle as its partner is used directly, so the
   // update always lands on the edge that completes the second handshake.
   assign aw_fire  = s_awvalid & s_awready;
   assign w_fire   = s_wvalid & s_wready;
   assign wr_addr  = have_aw ? aw_q : s_awaddr;
   assign wr_data  = have_w ? w_q : s_wdata;
   assign wr_strb  = have_w ? strb_q : s_wstrb;
   assign do_write = (wstate == W_IDLE) & (have_aw | aw_fire) & (have_w | w_fire);
   assign wr_reg   = reg_decode(wr_addr);
   assign wr_cfg   = !(wr_reg inside {REG_CTRL, REG_STATUS, REG_NONE});
   assign wr_err   = (wr_reg == REG_NONE) | (busy & wr_cfg)
                   | (busy & (wr_reg == REG_CTRL) & wr_strb[0] & wr_data[0]);
   assign wr_ok    = do_write & ~wr_err;
   assign done_set = core_done & busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wstate    <= W_IDLE;
         s_awready <= 1'b0;
         s_wready  <= 1'b0;
         s_bvalid  <= 1'b0;
         s_bresp   <= RESP_OKAY;
         have_aw   <= 1'b0;
         have_w    <= 1'b0;
         aw_q      <= '0;
         w_q       <= '0;
         strb_q    <= '0;
      end else begin
         case (wstate)
            W_IDLE: begin
               if (do_write) begin
                  have_aw   <= 1'b0;
                  have_w    <= 1'b0;
                  s_awready <= 1'b0;
                  s_wready  <= 1'b0;
                  s_bvalid  <= 1'b1;
                  s_bresp   <= wr_err ? RESP_SLVERR : RESP_OKAY;
                  wstate    <= W_RESP;
               end else begin
                  if (aw_fire) begin
                     aw_q      <= s_awaddr;
                     have_aw   <= 1'b1;
                     s_awready <= 1'b0;
                  end else if (!have_aw) begin
                     s_awready <= 1'b1;
                  end
                  if (w_fire) begin
                     w_q      <= s_wdata;
                     strb_q   <= s_wstrb;
                     have_w   <= 1'b1;
                     s_wready <= 1'b0;
                  end else if (!have_w) begin
                     s_wready <= 1'b1;
                  end
               end
            end
            W_RESP: begin
               if (s_bready) begin
                  s_bvalid  <= 1'b0;
                  s_awready <= 1'b1;
                  s_wready  <= 1'b1;
                  wstate    <= W_IDLE;
               end
            end
            default: wstate <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         irq_en     <= 1'b0;
         start_q    <= 1'b0;
         core_start <= 1'b0;
      end else begin
         core_start <= start_q;
         start_q    <= 1'b0;
         if (done_set) begin
            busy <= 1'b0;
            done <= 1'b1;
         end
         if (wr_ok) begin
            case (wr_reg)
               REG_CTRL: if (wr_strb[0]) begin
                  irq_en <= wr_data[1];
                  if (wr_data[0]) begin
                     busy    <= 1'b1;
                     done    <= 1'b0;
                     start_q <= 1'b1;
                  end
               end
               // a completion in the same cycle outranks the host clearing DONE
               REG_STATUS: if (wr_strb[0] && wr_data[1] && !done_set) done <= 1'b0;
               REG_DIN_BASE:  cfg.dat_in_base         <= strb_merge(cfg.dat_in_base, wr_data, wr_strb);
               REG_DIN_HSTR:  cfg.dat_in_head_stride  <= strb_merge(cfg.dat_in_head_stride, wr_data, wr_strb);
               REG_DIN_LSTR:  cfg.dat_in_line_stride  <= strb_merge(cfg.dat_in_line_stride, wr_data, wr_strb);
               REG_WT_BASE:   cfg.wt_base             <= strb_merge(cfg.wt_base, wr_data, wr_strb);
               REG_DOUT_BASE: cfg.dat_out_base        <= strb_merge(cfg.dat_out_base, wr_data, wr_strb);
               REG_DOUT_HSTR: cfg.dat_out_head_stride <= strb_merge(cfg.dat_out_head_stride, wr_data, wr_strb);
               REG_DOUT_LSTR: cfg.dat_out_line_stride <= strb_merge(cfg.dat_out_line_stride, wr_data, wr_strb);
               REG_TOKEN: cfg.token <= CFG_TOKEN_W'(strb_merge(32'(cfg.token), wr_data, wr_strb));
               REG_FHEAD: cfg.feature_head <= CFG_HEAD_W'(strb_merge(32'(cfg.feature_head), wr_data, wr_strb));
               REG_WHEAD: cfg.weight_head  <= CFG_HEAD_W'(strb_merge(32'(cfg.weight_head), wr_data, wr_strb));
               REG_KV: if (wr_strb[0]) cfg.kv_cache_mode <= wr_data[0];
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      rd_reg = reg_decode(s_araddr);
      rd_val = '0;
      rd_err = 1'b0;
      case (rd_reg)
         REG_CTRL:      rd_val = {30'd0, irq_en, 1'b0};
         REG_STATUS:    rd_val = {30'd0, done, busy};
         REG_DIN_BASE:  rd_val = cfg.dat_in_base;
         REG_DIN_HSTR:  rd_val = cfg.dat_in_head_stride;
         REG_DIN_LSTR:  rd_val = cfg.dat_in_line_stride;
         REG_WT_BASE:   rd_val = cfg.wt_base;
         REG_DOUT_BASE: rd_val = cfg.dat_out_base;
         REG_DOUT_HSTR: rd_val = cfg.dat_out_head_stride;
         REG_DOUT_LSTR: rd_val = cfg.dat_out_line_stride;
         REG_TOKEN:     rd_val = 32'(cfg.token);
         REG_FHEAD:     rd_val = 32'(cfg.feature_head);
         REG_WHEAD:     rd_val = 32'(cfg.weight_head);
         REG_KV:        rd_val = {31'd0, cfg.kv_cache_mode};
         default:       rd_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rstate    <= R_IDLE;
         s_arready <= 1'b0;
         s_rvalid  <= 1'b0;
         s_rdata   <= '0;
         s_rresp   <= RESP_OKAY;
      end else begin
         case (rstate)
            R_IDLE: begin
               if (s_arvalid && s_arready) begin
                  s_rdata   <= rd_val;
                  s_rresp   <= rd_err ? RESP_SLVERR : RESP_OKAY;
                  s_rvalid  <= 1'b1;
                  s_arready <= 1'b0;
                  rstate    <= R_DATA;
               end else begin
                  s_arready <= 1'b1;
               end
            end
            R_DATA: begin
               if (s_rready) begin
                  s_rvalid  <= 1'b0;
                  s_arready <= 1'b1;
                  rstate    <= R_IDLE;
               end
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end

   assign cfg_dat_in_base         = cfg.dat_in_base;
   assign cfg_dat_in_head_stride  = cfg.dat_in_head_stride;
   assign cfg_dat_in_line_stride  = cfg.dat_in_line_stride;
   assign cfg_wt_base             = cfg.wt_base;
   assign cfg_dat_out_base        = cfg.dat_out_base;
   assign cfg_dat_out_head_stride = cfg.dat_out_head_stride;
   assign cfg_dat_out_line_stride = cfg.dat_out_line_stride;
   assign cfg_token               = cfg.token;
   assign cfg_feature_head        = cfg.feature_head;
   assign cfg_weight_head         = cfg.weight_head;
   assign cfg_kv_cache_mode       = cfg.kv_cache_mode;
   assign irq                     = done & irq_en;

endmodule
